// File: rtl/req_arbiter3_if.sv
// Request/grant bundle between three requesters and the shared-resource arbiter.
// Handshake: a requester holds req[i] high until done; it owns the resource in every cycle its gnt[i] is high.
interface req_arbiter3_if;
   logic       rr_mode;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;
   logic       dbg_state;  // 0 = IDLE, 1 = GRANT

   modport master (
      output rr_mode, req,
      input  gnt, gnt_id, busy, timeout, dbg_state
   );

   modport slave (
      input  rr_mode, req,
      output gnt, gnt_id, busy, timeout, dbg_state
   );
endinterface

// File: rtl/req_arbiter3.sv
// Three-way arbiter: fixed-priority or round-robin, registered one-hot grant,
// grant hold with MAX_HOLD timeout and one-shot masking of the timed-out owner.
module req_arbiter3 #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input logic          clk,
   input logic          reset_n,
   req_arbiter3_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [2:0]          gnt_q, gnt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [2:0]          mask_q, mask_d;
   logic [1:0]          last_q, last_d;
   logic                timeout_q, timeout_d;

   logic [2:0]          masked;
   logic [2:0]          elig;
   logic [1:0]          winner;

   // First set index of e scanning upward from (last+1) mod 3; later k overwritten by earlier k.
   function automatic logic [1:0] rr_pick(input logic [2:0] e, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         idx = 2'((int'(last) + 1 + k) % 3);
         if (e[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      masked = bus.req & ~mask_q;
      elig   = (masked != 3'b000) ? masked : bus.req;
      if (bus.rr_mode) begin
         winner = rr_pick(elig, last_q);
      end else begin
         winner = elig[2] ? 2'd2 : (elig[1] ? 2'd1 : 2'd0);
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      hold_d    = hold_q;
      mask_d    = mask_q;
      last_d    = last_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (elig != 3'b000) begin
               gnt_d   = 3'b001 << winner;
               hold_d  = HOLD_W'(1);
               mask_d  = 3'b000;
               last_d  = winner;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if ((bus.req & gnt_q) == 3'b000) begin
               gnt_d   = 3'b000;
               hold_d  = '0;
               state_d = IDLE;
            end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
               gnt_d     = 3'b000;
               hold_d    = '0;
               timeout_d = 1'b1;
               mask_d    = gnt_q;
               state_d   = IDLE;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            gnt_d   = 3'b000;
            hold_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         gnt_q     <= 3'b000;
         hold_q    <= '0;
         mask_q    <= 3'b000;
         last_q    <= 2'd2;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         hold_q    <= hold_d;
         mask_q    <= mask_d;
         last_q    <= last_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_q[2] ? 2'd3 : (gnt_q[1] ? 2'd2 : (gnt_q[0] ? 2'd1 : 2'd0));
   assign bus.busy      = |gnt_q;
   assign bus.timeout   = timeout_q;
   assign bus.dbg_state = state_q;

endmodule
